hazard_stall_ctrl: RTL and testbench

//  Interlock controller in the ID stage, beside the bypass controller.

---
 rtl/hazard_stall_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// ID-stage interlock: load-use, MULDIV RAW and MULDIV structural stalls.
// Also sequences the multi-cycle MULDIV unit and flags its writeback.
module hazard_stall_ctrl #(
    parameter int MD_LAT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] rs_addr,
    input  logic [4:0] rt_addr,
    input  logic       rs_used,
    input  logic       rt_used,
    input  logic [4:0] ex_rd_addr,
    input  logic       ex_is_load,
    input  logic       ex_regwrite,
    input  logic       md_start,
    input  logic [4:0] md_rd_addr,
    output logic       stall,
    output logic       bubble,
    output logic       md_busy,
    output logic       md_done,
    output logic [4:0] md_wb_addr
);

    localparam int CW = $clog2(MD_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [4:0]    pend;
    logic [4:0]    pend_nx;

    logic occupied;
    logic rs_lu;
    logic rt_lu;
    logic rs_md;
    logic rt_md;
    logic hz_lu;
    logic hz_md;
    logic hz_st;
    logic hold;

    assign occupied = (state != IDLE);

    assign rs_lu = rs_used & (rs_addr == ex_rd_addr);
    assign rt_lu = rt_used & (rt_addr == ex_rd_addr);
    assign hz_lu = ex_is_load & ex_regwrite
                 & (ex_rd_addr != 5'd0) & (rs_lu | rt_lu);

    assign rs_md = rs_used & (rs_addr == pend);
    assign rt_md = rt_used & (rt_addr == pend);
    assign hz_md = occupied & (pend != 5'd0) & (rs_md | rt_md);

    assign hz_st = md_start & occupied;

    assign hold = id_valid & (hz_lu | hz_md | hz_st);

    // Outputs are forced low while reset is held.
    assign stall      = ~reset & hold;
    assign bubble     = ~reset & hold;
    assign md_busy    = ~reset & occupied;
    assign md_done    = ~reset & (state == DONE);
    assign md_wb_addr = md_done ? pend : 5'd0;

    // MULDIV sequencing: accept, count latency, one-cycle writeback.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pend_nx  = pend;
        unique case (state)
            IDLE: begin
                if (id_valid & md_start & ~hold) begin
                    pend_nx  = md_rd_addr;
                    cnt_nx   = CW'(MD_LAT - 1);
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; abandons any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= 5'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            pend  <= pend_nx;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: MD_LAT=4 and MD_LAT=1 instances.
// Occupancy model plus directed literal checks.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] rs_addr = '0;
    logic [4:0] rt_addr = '0;
    logic       rs_used = 1'b0;
    logic       rt_used = 1'b0;
    logic [4:0] ex_rd_addr = '0;
    logic       ex_is_load = 1'b0;
    logic       ex_regwrite = 1'b0;
    logic       md_start = 1'b0;
    logic [4:0] md_rd_addr = '0;

    logic [1:0] stall;
    logic [1:0] bubble;
    logic [1:0] md_busy;
    logic [1:0] md_done;
    logic [4:0] wb0;
    logic [4:0] wb1;

    int total = 0;
    int bad = 0;

    // Model: cycles of occupancy remaining, and pending destination.
    int         rem  [2] = '{0, 0};
    logic [4:0] pend [2] = '{5'd0, 5'd0};
    int         lat  [2] = '{4, 1};

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MD_LAT(4)) dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_used(rs_used), .rt_used(rt_used),
        .ex_rd_addr(ex_rd_addr), .ex_is_load(ex_is_load),
        .ex_regwrite(ex_regwrite), .md_start(md_start),
        .md_rd_addr(md_rd_addr), .stall(stall[0]),
        .bubble(bubble[0]), .md_busy(md_busy[0]),
        .md_done(md_done[0]), .md_wb_addr(wb0)
    );

    hazard_stall_ctrl #(.MD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_used(rs_used), .rt_used(rt_used),
        .ex_rd_addr(ex_rd_addr), .ex_is_load(ex_is_load),
        .ex_regwrite(ex_regwrite), .md_start(md_start),
        .md_rd_addr(md_rd_addr), .stall(stall[1]),
        .bubble(bubble[1]), .md_busy(md_busy[1]),
        .md_done(md_done[1]), .md_wb_addr(wb1)
    );

    task automatic chk(input string n, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", n, got, exp, $time);
        end
    endtask

    function automatic bit reads(input logic [4:0] a);
        return (a != 5'd0) &&
               ((rs_used && rs_addr == a) || (rt_used && rt_addr == a));
    endfunction

    function automatic bit want_stall(input int k);
        bit lu;
        bit md;
        bit st;
        lu = ex_is_load && ex_regwrite && reads(ex_rd_addr);
        md = (rem[k] > 0) && reads(pend[k]);
        st = md_start && (rem[k] > 0);
        return !reset && id_valid && (lu || md || st);
    endfunction

    // Model update at each clock edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                rem[k]  = 0;
                pend[k] = 5'd0;
            end else if (id_valid && md_start && !want_stall(k)
                         && rem[k] == 0) begin
                rem[k]  = lat[k] + 1;
                pend[k] = md_rd_addr;
            end else if (rem[k] > 0) begin
                rem[k] = rem[k] - 1;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit dn;
            dn = !reset && rem[k] == 1;
            chk($sformatf("d%0d_stall", k), int'(stall[k]),
                int'(want_stall(k)));
            chk($sformatf("d%0d_bubble", k), int'(bubble[k]),
                int'(want_stall(k)));
            chk($sformatf("d%0d_busy", k), int'(md_busy[k]),
                int'(!reset && rem[k] > 0));
            chk($sformatf("d%0d_done", k), int'(md_done[k]), int'(dn));
            chk($sformatf("d%0d_wb", k),
                (k == 0) ? int'(wb0) : int'(wb1),
                dn ? int'(pend[k]) : 0);
        end
    end

    // One cycle of ID/EX inputs; returns just after the falling edge.
    task automatic go(input bit v,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input bit rsu, input bit rtu,
                      input logic [4:0] exrd, input bit ld,
                      input bit mds, input logic [4:0] mdrd);
        @(posedge clk);
        #1;
        id_valid    = v;
        rs_addr     = rs;
        rt_addr     = rt;
        rs_used     = rsu;
        rt_used     = rtu;
        ex_rd_addr  = exrd;
        ex_is_load  = ld;
        ex_regwrite = ld;
        md_start    = mds;
        md_rd_addr  = mdrd;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        go(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        // Reset with a live load-use pattern: outputs stay low.
        reset = 1'b1;
        go(1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 5'd3);
        chk("rst_stall", int'(stall[0]), 0);
        chk("rst_busy", int'(md_busy[0]), 0);
        go(1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 5'd0);
        reset = 1'b0;

        // Load-use.
        go(1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 5'd0);
        chk("lu_stall", int'(stall[0]), 1);
        chk("lu_bubble", int'(bubble[0]), 1);
        go(1, 5'd5, 5'd0, 1, 0, 5'd0, 0, 0, 5'd0);
        chk("lu_release", int'(stall[0]), 0);
        go(1, 5'd5, 5'd0, 0, 0, 5'd5, 1, 0, 5'd0);
        chk("lu_unused", int'(stall[0]), 0);
        go(1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 5'd0);
        chk("lu_r0", int'(stall[0]), 0);
        go(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 5'd0);
        chk("no_valid", int'(stall[0]), 0);

        // MULDIV RAW: issue rd=9 at cycle 0, dependent rt=9.
        go(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd9);
        chk("md_issue", int'(stall[0]), 0);
        for (int c = 1; c <= 5; c++) begin
            go(1, 5'd0, 5'd9, 0, 1, 5'd0, 0, 0, 5'd0);
            chk($sformatf("raw_stall_c%0d", c), int'(stall[0]), 1);
            if (c == 2) begin
                chk("lat1_done", int'(md_done[1]), 1);
                chk("lat1_wb", int'(wb1), 9);
            end
            if (c == 5) begin
                chk("raw_done", int'(md_done[0]), 1);
                chk("raw_wb", int'(wb0), 9);
            end
        end
        go(1, 5'd0, 5'd9, 0, 1, 5'd0, 0, 0, 5'd0);
        chk("raw_release", int'(stall[0]), 0);
        chk("raw_idle", int'(md_busy[0]), 0);
        idle();

        // Structural: second issue waits for IDLE.
        go(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd3);
        for (int c = 1; c <= 5; c++) begin
            go(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd4);
            chk($sformatf("st_stall_c%0d", c), int'(stall[0]), 1);
        end
        go(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd4);
        chk("st_accept", int'(stall[0]), 0);
        idle();
        chk("st_busy", int'(md_busy[0]), 1);
        repeat (8) idle();

        // Load-use and MULDIV RAW together: one stall.
        go(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd7);
        go(1, 5'd7, 5'd0, 1, 0, 5'd7, 1, 0, 5'd0);
        chk("dual_stall", int'(stall[0]), 1);
        repeat (6) idle();

        // Issue blocked by load-use is not accepted.
        go(1, 5'd8, 5'd0, 1, 0, 5'd8, 1, 1, 5'd8);
        chk("blk_stall", int'(stall[0]), 1);
        idle();
        chk("blk_idle", int'(md_busy[0]), 0);

        // MULDIV to $0: occupied, no RAW stall, done with wb=0.
        go(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd0);
        go(1, 5'd0, 5'd0, 0, 1, 5'd0, 0, 0, 5'd0);
        chk("r0_nostall", int'(stall[0]), 0);
        chk("r0_busy", int'(md_busy[0]), 1);
        for (int c = 2; c <= 5; c++) idle();
        chk("r0_done", int'(md_done[0]), 1);
        chk("r0_wb", int'(wb0), 0);
        repeat (2) idle();

        // Reset mid-operation.
        go(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd9);
        idle();
        reset = 1'b1;
        go(1, 5'd9, 5'd0, 1, 0, 5'd9, 1, 1, 5'd3);
        chk("mr_stall", int'(stall[0]), 0);
        chk("mr_busy", int'(md_busy[0]), 0);
        chk("mr_done", int'(md_done[0]), 0);
        chk("mr_wb", int'(wb0), 0);
        reset = 1'b0;
        idle();
        chk("mr_after", int'(md_busy[0]), 0);
        for (int c = 0; c < 6; c++) begin
            idle();
            chk($sformatf("mr_nodone_%0d", c), int'(md_done[0]), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
